// File: rtl/add_32.sv
// rtl/add_32.sv - registered 32-bit carry-lookahead adder; ADD32_PIPE2_EN selects a two-stage pipeline
//
// Build option:
//   ADD32_PIPE2_EN undefined : single register stage, latency 1.
//   ADD32_PIPE2_EN defined   : low half and the bit-15 carry are registered first,
//                              the upper half is resolved in the second stage, latency 2.
//
// The adder is eight 4-bit carry-lookahead groups linked by their group carries.
// Groups 0..3 form the low half and groups 4..7 the high half, so the pipelined
// build only has to cut the chain at the group 3 -> group 4 carry.

// One 4-bit carry-lookahead group: every internal carry is formed directly from
// the group carry-in and the generate/propagate terms, with no ripple inside the group.
module add_32_cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = a & b;
  assign p = a ^ b;

  assign c[0] = ci;
  assign c[1] = g[0]
              | (p[0] & ci);
  assign c[2] = g[1]
              | (p[1] & g[0])
              | (p[1] & p[0] & ci);
  assign c[3] = g[2]
              | (p[2] & g[1])
              | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & ci);
  assign c[4] = g[3]
              | (p[3] & g[2])
              | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & ci);

  assign s  = p ^ c[3:0];
  assign co = c[4];

endmodule

module add_32 #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_SUM = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             out_valid
);

  // Low half: groups 0..3, always fed straight from the operand ports.
  logic [4:0]  c_lo;
  logic [15:0] sum_lo_comb;

  assign c_lo[0] = cin;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lo
      add_32_cla4 u_grp (
        .a  (a[4*gi+3:4*gi]),
        .b  (b[4*gi+3:4*gi]),
        .ci (c_lo[gi]),
        .s  (sum_lo_comb[4*gi+3:4*gi]),
        .co (c_lo[gi+1])
      );
    end
  endgenerate

  // Signals seen by the high half and the output register. They come either
  // directly from the ports or from the first pipeline stage.
  logic [15:0] hi_a;
  logic [15:0] hi_b;
  logic        hi_cin;
  logic [15:0] fin_sum_lo;
  logic        fin_valid;

`ifdef ADD32_PIPE2_EN
  logic        s1_valid;
  logic [15:0] s1_sum_lo;
  logic        s1_c16;
  logic [15:0] s1_a_hi;
  logic [15:0] s1_b_hi;

  // Stage 1: capture the finished low half, its carry and the untouched upper operands.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sum_lo <= sum_lo_comb;
        s1_c16    <= c_lo[4];
        s1_a_hi   <= a[31:16];
        s1_b_hi   <= b[31:16];
      end
    end
  end

  assign hi_a       = s1_a_hi;
  assign hi_b       = s1_b_hi;
  assign hi_cin     = s1_c16;
  assign fin_sum_lo = s1_sum_lo;
  assign fin_valid  = s1_valid;
`else
  assign hi_a       = a[31:16];
  assign hi_b       = b[31:16];
  assign hi_cin     = c_lo[4];
  assign fin_sum_lo = sum_lo_comb;
  assign fin_valid  = in_valid;
`endif

  // High half: groups 4..7, chained from the bit-15 carry.
  logic [4:0]  c_hi;
  logic [15:0] sum_hi_comb;

  assign c_hi[0] = hi_cin;

  generate
    for (gi = 0; gi < 4; gi++) begin : g_hi
      add_32_cla4 u_grp (
        .a  (hi_a[4*gi+3:4*gi]),
        .b  (hi_b[4*gi+3:4*gi]),
        .ci (c_hi[gi]),
        .s  (sum_hi_comb[4*gi+3:4*gi]),
        .co (c_hi[gi+1])
      );
    end
  endgenerate

  logic [WIDTH-1:0] sum_next;
  logic             ovf_next;

  assign sum_next = {sum_hi_comb, fin_sum_lo};
  // Like-signed operands giving an opposite-signed result; cin is already folded into sum_next.
  assign ovf_next = (hi_a[15] == hi_b[15]) && (sum_next[31] != hi_a[15]);

  // Output register: results update only on valid cycles and hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum       <= RESET_SUM;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= (RESET_SUM == '0);
      out_valid <= 1'b0;
    end else begin
      out_valid <= fin_valid;
      if (fin_valid) begin
        sum  <= sum_next;
        cout <= c_hi[4];
        ovf  <= ovf_next;
        zero <= ~|sum_next;
      end
    end
  end

endmodule

// File: tb/tb_add_32.sv
// tb/tb_add_32.sv - self-checking bench for add_32 (honours ADD32_PIPE2_EN latency)

module tb_add_32;

`ifdef ADD32_PIPE2_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk;
  logic        rst;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  logic        in_valid;
  logic [31:0] sum;
  logic        cout;
  logic        ovf;
  logic        zero;
  logic        out_valid;

  add_32 dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .in_valid  (in_valid),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string nm, input logic [32:0] act, input logic [32:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Literal expectation attached to the operation currently being driven.
  logic        lit_en;
  logic [32:0] lit_r;
  logic        lit_ovf;

  typedef struct packed {
    logic        v;
    logic [32:0] r;
    logic        ov;
    logic        lit;
    logic [32:0] lr;
    logic        lov;
  } ent_t;

  ent_t        pipe [0:1];
  logic        chk_en = 1'b0;
  logic        ex_valid;
  logic [31:0] ex_sum;
  logic        ex_cout;
  logic        ex_ovf;
  logic        ex_zero;

  // Reference model: plain 33-bit and signed 64-bit arithmetic, delayed by LAT edges.
  initial begin
    ent_t   e;
    ent_t   head;
    longint sv;
    forever begin
      @(posedge clk);
      if (rst) begin
        pipe[0]  = '0;
        pipe[1]  = '0;
        ex_valid = 1'b0;
        ex_sum   = 32'h0;
        ex_cout  = 1'b0;
        ex_ovf   = 1'b0;
        ex_zero  = 1'b1;
        chk_en   = 1'b1;
      end else begin
        sv    = longint'($signed(a)) + longint'($signed(b)) + longint'(cin);
        e.v   = in_valid;
        e.r   = {1'b0, a} + {1'b0, b} + {32'h0, cin};
        e.ov  = (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
        e.lit = lit_en;
        e.lr  = lit_r;
        e.lov = lit_ovf;
        pipe[1] = pipe[0];
        pipe[0] = e;
        head = pipe[LAT-1];
        ex_valid = head.v;
        if (head.v) begin
          ex_sum  = head.r[31:0];
          ex_cout = head.r[32];
          ex_ovf  = head.ov;
          ex_zero = (head.r[31:0] == 32'h0);
          if (head.lit) begin
            check("model_result", head.r, head.lr);
            check("model_ovf", {32'h0, head.ov}, {32'h0, head.lov});
          end
        end
      end
    end
  end

  // Compare DUT against the model on every cycle, away from the rising edge.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("out_valid", {32'h0, out_valid}, {32'h0, ex_valid});
        check("sum", {1'b0, sum}, {1'b0, ex_sum});
        check("cout", {32'h0, cout}, {32'h0, ex_cout});
        check("ovf", {32'h0, ovf}, {32'h0, ex_ovf});
        check("zero", {32'h0, zero}, {32'h0, ex_zero});
      end
    end
  end

  task automatic drive(input logic r, input logic v, input logic [31:0] aa, input logic [31:0] bb,
                       input logic c, input logic le, input logic [32:0] lr, input logic lo);
    @(negedge clk);
    rst      = r;
    in_valid = v;
    a        = aa;
    b        = bb;
    cin      = c;
    lit_en   = le;
    lit_r    = lr;
    lit_ovf  = lo;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 33'h0, 1'b0);
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    a        = 32'h0;
    b        = 32'h0;
    cin      = 1'b0;
    lit_en   = 1'b0;
    lit_r    = 33'h0;
    lit_ovf  = 1'b0;

    @(negedge clk);
    check("rst_out_valid", {32'h0, out_valid}, 33'h0);
    check("rst_sum", {1'b0, sum}, 33'h0);
    check("rst_zero", {32'h0, zero}, 33'h1);

    // Directed vectors with hand-computed {cout,sum} and ovf.
    drive(1'b0, 1'b1, 32'd2, 32'd1, 1'b1, 1'b1, 33'h0_0000_0004, 1'b0);
    drive(1'b0, 1'b1, 32'd5, 32'd3, 1'b0, 1'b1, 33'h0_0000_0008, 1'b0);
    drive(1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b1, 33'h1_0000_0000, 1'b0);
    drive(1'b0, 1'b1, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b1, 33'h0_8000_0000, 1'b1);
    drive(1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1, 33'h1_0000_0000, 1'b1);
    drive(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 33'h1_8000_0000, 1'b0);
    drive(1'b0, 1'b1, 32'h0000_FFFF, 32'h0000_0000, 1'b1, 1'b1, 33'h0_0001_0000, 1'b0);
    idle(3);

    // Reset with operands present: they are dropped and the reset state appears.
    drive(1'b1, 1'b1, 32'd10, 32'd20, 1'b0, 1'b0, 33'h0, 1'b0);
    @(negedge clk);
    check("rst_drop_valid", {32'h0, out_valid}, 33'h0);
    check("rst_drop_sum", {1'b0, sum}, 33'h0);
    check("rst_drop_cout", {32'h0, cout}, 33'h0);
    check("rst_drop_zero", {32'h0, zero}, 33'h1);
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("hold_valid", {32'h0, out_valid}, 33'h0);
    check("hold_sum", {1'b0, sum}, 33'h0);
    check("hold_zero", {32'h0, zero}, 33'h1);

    // Result in flight discarded by reset.
    drive(1'b0, 1'b1, 32'd100, 32'd200, 1'b0, 1'b0, 33'h0, 1'b0);
    drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 33'h0, 1'b0);
    @(negedge clk);
    check("inflight_valid", {32'h0, out_valid}, 33'h0);
    check("inflight_sum", {1'b0, sum}, 33'h0);
    rst = 1'b0;
    idle(2);

    // Random operands with gapped valids and occasional resets.
    for (int i = 0; i < 1000; i++) begin
      drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), $urandom, $urandom,
            1'($urandom_range(0, 1)), 1'b0, 33'h0, 1'b0);
    end
    idle(4);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/add_32.md
Name: add_32

Overview:
- Registered 32-bit binary adder with carry-in, carry-out and status flags.
- Computes sum = a + b + cin and presents the result one clock after the operands are accepted.
- Used as the integer add primitive in datapath and ALU blocks.
- Internally built from eight 4-bit carry-lookahead groups chained by group carries, not a behavioural "+".

Parameters:
- WIDTH, 32, operand/result width; fixed at 32, all behaviour below assumes 32.
- RESET_SUM, 32'h0000_0000, value loaded into sum on reset.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- a  input  32  operand A, unsigned or two's complement.
- b  input  32  operand B, unsigned or two's complement.
- cin  input  1  carry-in, added at bit 0.
- in_valid  input  1  operands valid this cycle.
- sum  output  32  registered result bits [31:0] of a+b+cin.
- cout  output  1  registered carry out of bit 31 (unsigned overflow).
- ovf  output  1  registered signed overflow.
- zero  output  1  registered flag, 1 when sum == 0.
- out_valid  output  1  registered; sum/cout/ovf/zero are valid when high.

Behaviour:
- Interface: one clock (clk). Reset (rst) is synchronous and active-high.
- Reset: on a rising clk edge with rst=1:
  - sum = RESET_SUM, cout = 0, ovf = 0, out_valid = 0.
  - zero = 1 if RESET_SUM == 0, else 0.
  - rst has priority over in_valid. Operands presented in the reset cycle are dropped.
- Arithmetic: full 33-bit result {cout, sum} = a + b + cin, modulo 2^33; no truncation of the carry.
- Carry structure:
  - Each 4-bit group generates g_i = a_i & b_i and p_i = a_i ^ b_i.
  - Carries within a group are lookahead from the group carry-in. Group carry-in of group 0 is cin.
  - sum_i = p_i ^ c_i.
- ovf = (a[31] == b[31]) && (sum[31] != a[31]); cin participates through sum[31].
- zero depends only on sum, not on cout.
- Latency: exactly 1 cycle. Operands with in_valid=1 at edge N appear on outputs after edge N, with out_valid=1.
- in_valid=0 at an edge:
  - out_valid goes 0.
  - sum/cout/ovf/zero hold their previous values (no update).
- Throughput: one operation per cycle. Back-to-back valid inputs produce back-to-back valid outputs. No backpressure, no ready signal.
- Outputs are purely registered; no combinational path from inputs to outputs.
- Reset mid-operation: a result in flight is discarded; out_valid=0 in the cycle after reset.

Optional Feature:
- Macro: ADD32_PIPE2_EN.
- When defined:
  - Two-stage pipeline, latency 2.
  - Stage 1 registers low sum[15:0], the carry out of bit 15, and operand bits a[31:16]/b[31:16].
  - Stage 2 computes the upper half using the registered carry, then registers all outputs.
  - out_valid follows in_valid delayed 2 cycles. Throughput remains 1 per cycle.
  - Reset clears both stages' valid bits and all output registers as above.
- When not defined: single-stage, latency 1, as described in Behaviour.

Test Plan:
- a=2, b=1, cin=1, in_valid=1 -> next cycle sum=4, cout=0, ovf=0, zero=0, out_valid=1.
- a=5, b=3, cin=0, issued back-to-back after the previous operation -> sum=8, cout=0, ovf=0; out_valid stays 1 on consecutive cycles.
- a=32'hFFFF_FFFF, b=0, cin=1 -> sum=0, cout=1, zero=1, ovf=0 (full carry ripple across all 8 groups).
- a=32'h7FFF_FFFF, b=1, cin=0 -> sum=32'h8000_0000, ovf=1, cout=0.
  - Also a=32'h8000_0000, b=32'h8000_0000, cin=0 -> sum=0, cout=1, ovf=1, zero=1.
- rst=1 asserted with in_valid=1 and a=10, b=20 -> after the edge out_valid=0, sum=0, cout=0, zero=1. Released rst with in_valid=0 -> outputs hold, out_valid=0.
- 1000 random a/b/cin with randomly gapped in_valid -> each output matches the 33-bit reference sum at the configured latency (1, or 2 with ADD32_PIPE2_EN).
